seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for an 8-digit common-anode seven-segment display.
- Takes a 32-bit value from the datapath through a load handshake and double-buffers it so that updates apply only at frame boundaries, which prevents tearing.
- Drives one shared segment bus plus per-digit enables.
- Inserts a guard interval between digits to suppress ghosting.
- Reuses the team's SevenSeg nibble decoder, one instance, muxed input.

---
 rtl/seg_scan_ctrl_if.sv | 33 +++
 rtl/seg_scan_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if
//   Bundles the datapath-facing signals of the seven-segment scan controller.
//   master : the datapath/host side (drives value, load strobe, controls).
//   slave  : the scan controller (drives the display bus and status).
//   Signals:
//     iEn       scan enable
//     iNum      32-bit value, nibble k shown on digit k
//     iLoad     one-cycle strobe capturing iNum
//     iBlankLZ  leading-zero blanking enable
//     oSeg      shared segment bus (active-low segments, gfedcba)
//     oAn       active-low digit enables, bit k = digit k
//     oPending  a loaded value is waiting for a frame boundary
//     oFrame    one-cycle pulse on display update / frame start
interface seg_scan_ctrl_if;
  logic        iEn;
  logic [31:0] iNum;
  logic        iLoad;
  logic        iBlankLZ;
  logic [6:0]  oSeg;
  logic [7:0]  oAn;
  logic        oPending;
  logic        oFrame;

  modport master (
    output iEn, iNum, iLoad, iBlankLZ,
    input  oSeg, oAn, oPending, oFrame
  );

  modport slave (
    input  iEn, iNum, iLoad, iBlankLZ,
    output oSeg, oAn, oPending, oFrame
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// SevenSeg
//   Nibble to seven-segment decoder for common-anode displays.
//   Segments are active-low, bit order gfedcba.
//   Ports: iNib (4-bit value), oSeg (7-bit segment pattern).
module SevenSeg (
  input  logic [3:0] iNib,
  output logic [6:0] oSeg
);
  always_comb begin
    oSeg = 7'h7F;
    case (iNib)
      4'h0: oSeg = 7'h40;
      4'h1: oSeg = 7'h79;
      4'h2: oSeg = 7'h24;
      4'h3: oSeg = 7'h30;
      4'h4: oSeg = 7'h19;
      4'h5: oSeg = 7'h12;
      4'h6: oSeg = 7'h02;
      4'h7: oSeg = 7'h78;
      4'h8: oSeg = 7'h00;
      4'h9: oSeg = 7'h10;
      4'hA: oSeg = 7'h08;
      4'hB: oSeg = 7'h03;
      4'hC: oSeg = 7'h46;
      4'hD: oSeg = 7'h21;
      4'hE: oSeg = 7'h06;
      4'hF: oSeg = 7'h0E;
      default: oSeg = 7'h7F;
    endcase
  end
endmodule

// seg_scan_ctrl
//   Time-multiplexed scan controller for an 8-digit common-anode display.
//   A loaded value is held in a pending register and moved to the display
//   register only at a frame boundary (or immediately while idle), so a
//   frame never shows a mix of old and new digits. Each digit slot is
//   CLK_DIV cycles: CLK_DIV-GUARD lit, then GUARD cycles all-dark.
//   Ports:
//     iClk    clock
//     iRst_n  asynchronous active-low reset
//     bus     seg_scan_ctrl_if.slave (see interface header for signals)
module seg_scan_ctrl #(
  parameter int         CLK_DIV = 50000,
  parameter int         GUARD   = 16,
  parameter logic [6:0] BLANK   = 7'h7F
) (
  input  logic            iClk,
  input  logic            iRst_n,
  seg_scan_ctrl_if.slave  bus
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] ON_LAST   = PW'(CLK_DIV - GUARD - 1);
  localparam logic [PW-1:0] SLOT_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GUARD} state_t;

  state_t        r_state, w_state_next;
  logic [2:0]    r_idx, w_idx_next;
  logic [PW-1:0] r_pre, w_pre_next;

  logic [31:0]   r_disp, r_pend;
  logic          r_pend_valid;
  logic          r_blz;
  logic [6:0]    r_seg;
  logic [7:0]    r_an;
  logic          r_frame;

  logic          w_boundary, w_xfer, w_slot_start, w_lit;
  logic [7:0]    w_lz;
  logic [3:0]    w_nib;
  logic [6:0]    w_dec;
  logic [7:0]    w_an_next;
  logic [6:0]    w_seg_next;

  // Digit k is a leading zero when it and every nibble above it are zero.
  // Digit 0 is never treated as leading, so a zero value still shows '0'.
  assign w_lz[0] = 1'b0;
  for (genvar gi = 1; gi < 8; gi++) begin : g_lz
    assign w_lz[gi] = (r_disp[31:4*gi] == '0);
  end

  // Single decoder shared by all digits; input muxed by the scan index.
  assign w_nib = r_disp[{r_idx, 2'b00} +: 4];

  SevenSeg u_dec (
    .iNib (w_nib),
    .oSeg (w_dec)
  );

  // State / counter register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_pre   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_pre   <= w_pre_next;
    end
  end

  // Next-state logic; the prescaler runs across the whole slot so the
  // ON/GUARD split is a compare rather than a second counter.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_pre_next   = r_pre;
    w_boundary   = 1'b0;
    if (!bus.iEn) begin
      w_state_next = S_IDLE;
      w_idx_next   = 3'd0;
      w_pre_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_ON;
          w_idx_next   = 3'd0;
          w_pre_next   = '0;
        end
        S_ON: begin
          w_pre_next = r_pre + 1'b1;
          if (r_pre == ON_LAST) w_state_next = S_GUARD;
        end
        S_GUARD: begin
          if (r_pre == SLOT_LAST) begin
            w_state_next = S_ON;
            w_pre_next   = '0;
            w_idx_next   = r_idx + 3'd1;
            w_boundary   = (r_idx == 3'd7);
          end else begin
            w_pre_next = r_pre + 1'b1;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_idx_next   = 3'd0;
          w_pre_next   = '0;
        end
      endcase
    end

    w_slot_start = (w_state_next == S_ON) && (r_state != S_ON);
    w_xfer       = r_pend_valid && (w_boundary || (r_state == S_IDLE));

    w_lit      = (r_state == S_ON) && !(r_blz && w_lz[r_idx]);
    w_an_next  = w_lit ? ~(8'd1 << r_idx) : 8'hFF;
    w_seg_next = w_lit ? w_dec : BLANK;
  end

  // Double buffer, blanking sample and registered outputs.
  // A load coinciding with a transfer wins on pend_valid so the new value
  // stays queued for the following frame.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_disp       <= 32'd0;
      r_pend       <= 32'd0;
      r_pend_valid <= 1'b0;
      r_blz        <= 1'b0;
      r_an         <= 8'hFF;
      r_seg        <= BLANK;
      r_frame      <= 1'b0;
    end else begin
      if (w_xfer) r_disp <= r_pend;
      if (bus.iLoad) begin
        r_pend       <= bus.iNum;
        r_pend_valid <= 1'b1;
      end else if (w_xfer) begin
        r_pend_valid <= 1'b0;
      end
      if (w_slot_start) r_blz <= bus.iBlankLZ;
      r_an    <= w_an_next;
      r_seg   <= w_seg_next;
      r_frame <= w_xfer || w_boundary;
    end
  end

  assign bus.oSeg     = r_seg;
  assign bus.oAn      = r_an;
  assign bus.oPending = r_pend_valid;
  assign bus.oFrame   = r_frame;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
//   Scoreboard bench for seg_scan_ctrl with CLK_DIV=8, GUARD=2.
//   The stimulus pushes expected lit slots (digit enable, segment code,
//   lit length, start-to-start spacing) into a queue; a negedge monitor
//   collects each lit run on oAn/oSeg and compares it against the queue.
//   Status outputs (oPending/oFrame/reset values) are checked inline.
module tb_seg_scan_ctrl;
  localparam int CLK_DIV = 8;
  localparam int GUARD   = 2;

  // Active-low segment codes, gfedcba
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78;
  localparam logic [6:0] S8 = 7'h00, SA = 7'h08, SB = 7'h03, SC = 7'h46;
  localparam logic [6:0] SD = 7'h21;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .GUARD(GUARD), .BLANK(7'h7F)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    int         len;
    int         delta;
  } slot_t;

  slot_t exp_q[$];
  int checks_total = 0;
  int checks_pass  = 0;
  int cyc  = 0;
  int base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks_total++;
    if (act === req) checks_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic push_slot(input int k, input logic [6:0] seg, input int len, input int delta);
    slot_t s;
    s.an    = ~(8'd1 << k);
    s.seg   = seg;
    s.len   = len;
    s.delta = delta;
    exp_q.push_back(s);
  endtask

  // segs is {digit7, ..., digit0}; every slot lit for the full ON time
  task automatic push_frame(input logic [55:0] segs, input int first_delta);
    for (int k = 0; k < 8; k++)
      push_slot(k, segs[7*k +: 7], CLK_DIV - GUARD, (k == 0) ? first_delta : CLK_DIV);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // return just after edge number k counted from the enable point
  task automatic at(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- monitor ----------------
  logic [7:0] run_an;
  logic [6:0] run_seg;
  int  run_len = 0, run_delta = -1, last_start = -1, ncyc = 0, blank_err = 0;
  bit  run_on = 1'b0;

  task automatic finish_run();
    slot_t e;
    checks_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL slot: unexpected run an=%h seg=%h len=%0d", run_an, run_seg, run_len);
      return;
    end
    e = exp_q.pop_front();
    if (run_an === e.an && run_seg === e.seg && run_len == e.len &&
        (e.delta < 0 || run_delta == e.delta)) begin
      checks_pass++;
      $display("slot an=%h seg=%h len=%0d dt=%0d ok", run_an, run_seg, run_len, run_delta);
    end else begin
      $display("FAIL slot: got an=%h seg=%h len=%0d dt=%0d, expected an=%h seg=%h len=%0d dt=%0d",
               run_an, run_seg, run_len, run_delta, e.an, e.seg, e.len, e.delta);
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (bus.oAn === 8'hFF && bus.oSeg !== 7'h7F) blank_err++;
    if (run_on && (bus.oAn !== run_an || bus.oSeg !== run_seg)) begin
      finish_run();
      run_on = 1'b0;
    end
    if (run_on) begin
      run_len++;
    end else if (bus.oAn !== 8'hFF && !$isunknown(bus.oAn)) begin
      run_on     = 1'b1;
      run_an     = bus.oAn;
      run_seg    = bus.oSeg;
      run_len    = 1;
      run_delta  = (last_start < 0) ? -1 : ncyc - last_start;
      last_start = ncyc;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.iEn = 1'b0; bus.iNum = 32'd0; bus.iLoad = 1'b0; bus.iBlankLZ = 1'b0;

    @(posedge clk); #1;
    check("rst_an",   {24'd0, bus.oAn},  32'hFF);
    check("rst_seg",  {25'd0, bus.oSeg}, 32'h7F);
    check("rst_pend", {31'd0, bus.oPending}, 32'd0);
    check("rst_frame",{31'd0, bus.oFrame},   32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // load while idle: immediate transfer
    bus.iNum = 32'h12345678; bus.iLoad = 1'b1;
    tick(1);
    bus.iLoad = 1'b0;
    check("idle_pend_set", {31'd0, bus.oPending}, 32'd1);
    check("idle_frame_lo", {31'd0, bus.oFrame},   32'd0);
    tick(1);
    check("idle_frame_hi", {31'd0, bus.oFrame},   32'd1);
    check("idle_pend_clr", {31'd0, bus.oPending}, 32'd0);
    tick(1);
    check("idle_frame_end",{31'd0, bus.oFrame},   32'd0);

    // frame 1: 12345678
    push_frame({S1, S2, S3, S4, S5, S6, S7, S8}, -1);
    base = cyc;
    bus.iEn = 1'b1;

    // two loads during digit 3; only the last may ever show
    push_frame({S0, S0, S0, S0, S0, S0, S0, S1}, 8);
    at(27); bus.iNum = 32'hDEADBEEF; bus.iLoad = 1'b1;
    at(28); bus.iNum = 32'h00000001;
    at(29); bus.iLoad = 1'b0;
    check("mid_pend", {31'd0, bus.oPending}, 32'd1);
    at(64);
    check("pre_bnd_pend",  {31'd0, bus.oPending}, 32'd1);
    check("pre_bnd_frame", {31'd0, bus.oFrame},   32'd0);
    at(65);
    check("bnd_frame", {31'd0, bus.oFrame},   32'd1);
    check("bnd_pend",  {31'd0, bus.oPending}, 32'd0);

    // frame 3 shows 0000ABCD loaded mid frame 2; A0 lands on the boundary
    push_frame({S0, S0, S0, S0, SA, SB, SC, SD}, 8);
    at(99);  bus.iNum = 32'h0000ABCD; bus.iLoad = 1'b1;
    at(100); bus.iLoad = 1'b0;
    push_slot(0, S0, 6, 8);
    push_slot(1, SA, 6, 8);
    at(128); bus.iNum = 32'h000000A0; bus.iLoad = 1'b1;
    at(129); bus.iLoad = 1'b0;
    check("coinc_frame", {31'd0, bus.oFrame},   32'd1);
    check("coinc_pend",  {31'd0, bus.oPending}, 32'd1);

    // blanking on from frame 4
    at(187); bus.iBlankLZ = 1'b1;
    at(193);
    check("f4_frame", {31'd0, bus.oFrame},   32'd1);
    check("f4_pend",  {31'd0, bus.oPending}, 32'd0);

    // frame 5: value 0 with blanking -> only digit 0
    push_slot(0, S0, 6, 56);
    at(199); bus.iNum = 32'h0; bus.iLoad = 1'b1;
    at(200); bus.iLoad = 1'b0;
    check("zero_pend", {31'd0, bus.oPending}, 32'd1);
    at(257);
    check("f5_frame", {31'd0, bus.oFrame}, 32'd1);

    // frame 6: blanking off; reset lands in digit 5 ON
    at(315); bus.iBlankLZ = 1'b0;
    push_slot(0, S0, 6, 64);
    for (int k = 1; k < 5; k++) push_slot(k, S0, 6, 8);
    push_slot(5, S0, 2, 8);
    at(321);
    check("f6_frame_nopend", {31'd0, bus.oFrame}, 32'd1);
    at(322);
    check("f6_frame_end", {31'd0, bus.oFrame}, 32'd0);
    at(364);
    rst_n = 1'b0; bus.iEn = 1'b0;
    #1;
    check("async_an",    {24'd0, bus.oAn},  32'hFF);
    check("async_seg",   {25'd0, bus.oSeg}, 32'h7F);
    check("async_pend",  {31'd0, bus.oPending}, 32'd0);
    check("async_frame", {31'd0, bus.oFrame},   32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("post_rst_an",   {24'd0, bus.oAn},      32'hFF);
    check("post_rst_pend", {31'd0, bus.oPending}, 32'd0);

    // rescan of cleared display; iEn dropped in digit 6 guard
    for (int k = 0; k < 7; k++) push_slot(k, S0, 6, (k == 0) ? -1 : 8);
    push_slot(0, S0, 6, 10);
    base = cyc;
    bus.iEn = 1'b1;
    at(56); bus.iEn = 1'b0;
    at(57);
    check("drop_an_guard", {24'd0, bus.oAn}, 32'hFF);
    at(58);
    check("drop_an_idle",  {24'd0, bus.oAn}, 32'hFF);
    bus.iEn = 1'b1;
    at(64); bus.iEn = 1'b0;
    tick(6);

    check("queue_empty", exp_q.size(), 32'd0);
    check("blank_on_dark", blank_err, 32'd0);

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end
endmodule
